// File: rtl/node_packet_pkg.sv
// rtl/node_packet_pkg.sv - packet field layout, packet type and LFSR step for node_packet_source
package node_packet_pkg;

  localparam int VALID_BIT  = 31;
  localparam int DEST_X_LSB = 27;
  localparam int DEST_Y_LSB = 23;
  localparam int SRC_X_LSB  = 19;
  localparam int SRC_Y_LSB  = 15;
  localparam int SEQ_BITS   = 15;
  localparam int COORD_BITS = 4;

  typedef struct packed {
    logic                  valid;
    logic [COORD_BITS-1:0] destX;
    logic [COORD_BITS-1:0] destY;
    logic [COORD_BITS-1:0] srcX;
    logic [COORD_BITS-1:0] srcY;
    logic [SEQ_BITS-1:0]   seq;
  } packet_t;

  // Fibonacci form, taps 16,14,13,11 map to bits 15,13,12,10
  function automatic logic [15:0] lfsrNext(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/node_packet_source_if.sv
// rtl/node_packet_source_if.sv - node-to-network injection port with hold backpressure
interface node_packet_source_if #(
  parameter int FIFO_WIDTH = 32
);
  logic [FIFO_WIDTH-1:0] nodeToNetworkData;
  logic                  nodeToNetworkWriteRequest;
  logic                  networkToNodeHoldRequest;

  modport master (
    output nodeToNetworkData,
    output nodeToNetworkWriteRequest,
    input  networkToNodeHoldRequest
  );

  modport slave (
    input  nodeToNetworkData,
    input  nodeToNetworkWriteRequest,
    output networkToNodeHoldRequest
  );
endinterface

// File: rtl/node_source_fifo.sv
// rtl/node_source_fifo.sv - synchronous injection queue; push and pop may coincide even when full
module node_source_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] pushData,
  output logic [WIDTH-1:0] headData,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign headData = mem[rdPtr];
  assign full     = (count == DEPTH_COUNT);
  assign empty    = (count == '0);
endmodule

// File: rtl/node_packet_source.sv
// rtl/node_packet_source.sv - per-node rate-limited packet injector feeding networkTori
module node_packet_source
  import node_packet_pkg::*;
#(
  parameter int          X_NODES     = 3,
  parameter int          Y_NODES     = 3,
  parameter int          FIFO_WIDTH  = 32,
  parameter int          NODE_ID     = 0,
  parameter int          QUEUE_DEPTH = 4,
  parameter int          RATE_PERIOD = 8,
  parameter int          DEST_MODE   = 0,
  parameter int          DEST_ID     = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  node_packet_source_if.master       net,
  output logic [15:0]                packetsSent,
  output logic [15:0]                packetsDropped,
  output logic                       queueEmpty
);
  localparam int NUM_NODES = X_NODES * Y_NODES;
  localparam int SRC_X     = NODE_ID % X_NODES;
  localparam int SRC_Y     = NODE_ID / X_NODES;
  localparam int RW        = (RATE_PERIOD > 1) ? $clog2(RATE_PERIOD) : 1;
  localparam logic [RW-1:0] RATE_LAST = RW'(RATE_PERIOD - 1);

  logic [RW-1:0]         rateCount;
  logic [SEQ_BITS-1:0]   seq;
  logic [15:0]           lfsr;
  logic [FIFO_WIDTH-1:0] dataReg;
  logic                  writeReg;
  logic [FIFO_WIDTH-1:0] newPacket;
  logic [FIFO_WIDTH-1:0] headData;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic                  genEvent;
  logic                  pop;
  logic                  accept;
  int                    destIdx;

  assign genEvent = enable && (rateCount == RATE_LAST);
  assign pop      = !fifoEmpty && !net.networkToNodeHoldRequest;
  assign accept   = genEvent && (!fifoFull || pop);

  // Random mode never targets this node: a self-hit moves to the next index
  always_comb begin
    destIdx = (DEST_MODE == 1) ? (int'(lfsr) % NUM_NODES) : DEST_ID;
    if ((DEST_MODE == 1) && (destIdx == NODE_ID)) destIdx = (destIdx + 1) % NUM_NODES;
    newPacket = '0;
    newPacket[VALID_BIT] = 1'b1;
    newPacket[DEST_X_LSB +: COORD_BITS] = COORD_BITS'(destIdx % X_NODES);
    newPacket[DEST_Y_LSB +: COORD_BITS] = COORD_BITS'(destIdx / X_NODES);
    newPacket[SRC_X_LSB +: COORD_BITS]  = COORD_BITS'(SRC_X);
    newPacket[SRC_Y_LSB +: COORD_BITS]  = COORD_BITS'(SRC_Y);
    newPacket[SEQ_BITS-1:0] = seq;
  end

  node_source_fifo #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (QUEUE_DEPTH)
  ) uFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (accept),
    .pop      (pop),
    .pushData (newPacket),
    .headData (headData),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rateCount      <= '0;
      seq            <= '0;
      lfsr           <= LFSR_SEED;
      dataReg        <= '0;
      writeReg       <= 1'b0;
      packetsSent    <= '0;
      packetsDropped <= '0;
    end else begin
      rateCount <= (rateCount == RATE_LAST) ? '0 : rateCount + 1'b1;
      // Sequence advances on drops too so the sink can see the gap
      if (genEvent) begin
        seq  <= seq + 1'b1;
        lfsr <= lfsrNext(lfsr);
        if (!accept && (packetsDropped != 16'hFFFF)) packetsDropped <= packetsDropped + 1'b1;
      end
      writeReg <= pop;
      if (pop) begin
        dataReg     <= headData;
        packetsSent <= packetsSent + 1'b1;
      end
    end
  end

  assign net.nodeToNetworkData         = dataReg;
  assign net.nodeToNetworkWriteRequest = writeReg;
  assign queueEmpty                    = fifoEmpty;
endmodule

// File: tb/tb_node_packet_source.sv
// tb/tb_node_packet_source.sv - directed bench for node_packet_source
module tb_node_packet_source;
  import node_packet_pkg::*;

  logic clk;
  logic reset;
  logic enable;
  logic [15:0] sentA, dropA, sentB, dropB, sentC, dropC;
  logic emptyA, emptyB, emptyC;
  int checks = 0;
  int errors = 0;

  node_packet_source_if #(.FIFO_WIDTH(32)) ifA();
  node_packet_source_if #(.FIFO_WIDTH(32)) ifB();
  node_packet_source_if #(.FIFO_WIDTH(32)) ifC();

  node_packet_source #(.X_NODES(3), .Y_NODES(3), .NODE_ID(8), .QUEUE_DEPTH(4), .RATE_PERIOD(8),
                       .DEST_MODE(0), .DEST_ID(0)) dutA (
    .clk(clk), .reset(reset), .enable(enable), .net(ifA),
    .packetsSent(sentA), .packetsDropped(dropA), .queueEmpty(emptyA));

  node_packet_source #(.X_NODES(3), .Y_NODES(3), .NODE_ID(4), .QUEUE_DEPTH(4), .RATE_PERIOD(2),
                       .DEST_MODE(1), .DEST_ID(0)) dutB (
    .clk(clk), .reset(reset), .enable(enable), .net(ifB),
    .packetsSent(sentB), .packetsDropped(dropB), .queueEmpty(emptyB));

  node_packet_source #(.X_NODES(3), .Y_NODES(3), .NODE_ID(0), .QUEUE_DEPTH(4), .RATE_PERIOD(1),
                       .DEST_MODE(0), .DEST_ID(5)) dutC (
    .clk(clk), .reset(reset), .enable(enable), .net(ifC),
    .packetsSent(sentC), .packetsDropped(dropC), .queueEmpty(emptyC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        expWr;
    logic [31:0] expData;
    logic [15:0] expSent;
    logic [15:0] expDropped;
    logic        expEmpty;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int strobes;
    int vi;
    int lfsrModel;
    int seqB;
    int idx;
    int fb;
    logic [31:0] expB;
    packet_t p;

    // Node 8 in 3x3 is (2,2), destination node 0 is (0,0): base word 0x80110000
    vecs = '{
      '{1,  1'b0, 32'h0,        16'd0, 16'd0, 1'b1},
      '{7,  1'b0, 32'h0,        16'd0, 16'd0, 1'b1},
      '{8,  1'b0, 32'h0,        16'd0, 16'd0, 1'b0},
      '{33, 1'b0, 32'h0,        16'd0, 16'd0, 1'b0},
      '{40, 1'b0, 32'h0,        16'd0, 16'd1, 1'b0},
      '{48, 1'b0, 32'h0,        16'd0, 16'd2, 1'b0},
      '{56, 1'b0, 32'h0,        16'd0, 16'd3, 1'b0},
      '{60, 1'b0, 32'h0,        16'd0, 16'd3, 1'b0},
      '{61, 1'b1, 32'h80110000, 16'd1, 16'd3, 1'b0},
      '{62, 1'b1, 32'h80110001, 16'd2, 16'd3, 1'b0},
      '{63, 1'b1, 32'h80110002, 16'd3, 16'd3, 1'b0},
      '{64, 1'b1, 32'h80110003, 16'd4, 16'd3, 1'b0},
      '{65, 1'b1, 32'h80110007, 16'd5, 16'd3, 1'b1},
      '{66, 1'b0, 32'h80110007, 16'd5, 16'd3, 1'b1}
    };

    enable = 1'b1;
    reset = 1'b1;
    ifA.networkToNodeHoldRequest = 1'b0;
    ifB.networkToNodeHoldRequest = 1'b0;
    ifC.networkToNodeHoldRequest = 1'b0;

    // Reset state and basic fixed-destination generation
    applyReset();
    check("reset data", ifA.nodeToNetworkData, 32'h0);
    check("reset wr", {31'b0, ifA.nodeToNetworkWriteRequest}, 32'd0);
    check("reset sent", {16'b0, sentA}, 32'd0);
    check("reset dropped", {16'b0, dropA}, 32'd0);
    check("reset empty", {31'b0, emptyA}, 32'd1);
    strobes = 0;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      tick();
      if (ifA.nodeToNetworkWriteRequest) strobes++;
      if (cyc == 8) check("p1 empty after event", {31'b0, emptyA}, 32'd0);
      if (cyc == 9) begin
        check("p1 first wr", {31'b0, ifA.nodeToNetworkWriteRequest}, 32'd1);
        check("p1 first data", ifA.nodeToNetworkData, 32'h80110000);
      end
      if (cyc == 17) begin
        check("p1 second wr", {31'b0, ifA.nodeToNetworkWriteRequest}, 32'd1);
        check("p1 second data", ifA.nodeToNetworkData, 32'h80110001);
        check("p1 sent", {16'b0, sentA}, 32'd2);
      end
    end
    check("p1 strobe count", strobes, 32'd2);

    // Hold for 60 cycles, then release: drain burst and sequence gap
    applyReset();
    strobes = 0;
    vi = 0;
    for (int cyc = 1; cyc <= 66; cyc++) begin
      ifA.networkToNodeHoldRequest = (cyc <= 60);
      tick();
      if (cyc <= 60 && ifA.nodeToNetworkWriteRequest) strobes++;
      if (vi < 14 && vecs[vi].cyc == cyc) begin
        check($sformatf("vec c%0d wr", cyc), {31'b0, ifA.nodeToNetworkWriteRequest}, {31'b0, vecs[vi].expWr});
        check($sformatf("vec c%0d data", cyc), ifA.nodeToNetworkData, vecs[vi].expData);
        check($sformatf("vec c%0d sent", cyc), {16'b0, sentA}, {16'b0, vecs[vi].expSent});
        check($sformatf("vec c%0d dropped", cyc), {16'b0, dropA}, {16'b0, vecs[vi].expDropped});
        check($sformatf("vec c%0d empty", cyc), {31'b0, emptyA}, {31'b0, vecs[vi].expEmpty});
        vi++;
      end
    end
    check("hold no strobes", strobes, 32'd0);

    // Reset with three packets queued discards them and restarts everything
    applyReset();
    for (int cyc = 1; cyc <= 42; cyc++) begin
      ifA.networkToNodeHoldRequest = (cyc != 41);
      reset = (cyc == 42);
      tick();
      if (cyc == 41) begin
        check("p4 pre wr", {31'b0, ifA.nodeToNetworkWriteRequest}, 32'd1);
        check("p4 pre sent", {16'b0, sentA}, 32'd1);
        check("p4 pre dropped", {16'b0, dropA}, 32'd1);
        check("p4 pre empty", {31'b0, emptyA}, 32'd0);
      end
    end
    check("p4 post wr", {31'b0, ifA.nodeToNetworkWriteRequest}, 32'd0);
    check("p4 post empty", {31'b0, emptyA}, 32'd1);
    check("p4 post sent", {16'b0, sentA}, 32'd0);
    check("p4 post dropped", {16'b0, dropA}, 32'd0);
    check("p4 post data", ifA.nodeToNetworkData, 32'h0);
    reset = 1'b0;
    ifA.networkToNodeHoldRequest = 1'b0;
    strobes = 0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      tick();
      if (cyc <= 8 && ifA.nodeToNetworkWriteRequest) strobes++;
    end
    check("p4 early strobes", strobes, 32'd0);
    check("p4 restart wr", {31'b0, ifA.nodeToNetworkWriteRequest}, 32'd1);
    check("p4 restart data", ifA.nodeToNetworkData, 32'h80110000);

    // Random destinations from node 4 (1,1): never self, always inside the mesh
    applyReset();
    lfsrModel = 32'hACE1;
    seqB = 0;
    strobes = 0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      tick();
      if (ifB.nodeToNetworkWriteRequest) begin
        idx = lfsrModel % 9;
        if (idx == 4) idx = 5;
        expB = 32'h80000000 | ((idx % 3) << 27) | ((idx / 3) << 23) | (1 << 19) | (1 << 15) | seqB;
        check($sformatf("rand pkt %0d", seqB), ifB.nodeToNetworkData, expB);
        p = packet_t'(ifB.nodeToNetworkData);
        check($sformatf("rand dest ok %0d", seqB),
              {31'b0, (p.destX < 3) && (p.destY < 3) && !(p.destX == 1 && p.destY == 1)}, 32'd1);
        fb = ((lfsrModel >> 15) ^ (lfsrModel >> 13) ^ (lfsrModel >> 12) ^ (lfsrModel >> 10)) & 1;
        lfsrModel = ((lfsrModel << 1) | fb) & 32'hFFFF;
        seqB++;
        strobes++;
      end
    end
    check("rand strobe count", strobes, 32'd99);
    check("rand dropped", {16'b0, dropB}, 32'd0);

    // Generation every cycle: one packet in flight, strobe every cycle
    applyReset();
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      check($sformatf("fast empty c%0d", cyc), {31'b0, emptyC}, 32'd0);
      if (cyc == 1) begin
        check("fast first wr", {31'b0, ifC.nodeToNetworkWriteRequest}, 32'd0);
      end else begin
        check($sformatf("fast wr c%0d", cyc), {31'b0, ifC.nodeToNetworkWriteRequest}, 32'd1);
        check($sformatf("fast data c%0d", cyc), ifC.nodeToNetworkData, 32'h90800000 | (cyc - 2));
      end
    end
    check("fast dropped", {16'b0, dropC}, 32'd0);
    check("fast sent", {16'b0, sentC}, 32'd39);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/node_packet_source.md
Name: node_packet_source

Overview:
- Per-node traffic injector sitting directly upstream of networkTori; one instance drives each node's nodeToNetwork* inputs.
- Generates header-tagged packets at a programmable rate and holds them in a small queue.
- Presents packets to the network one per cycle, honouring the network's hold backpressure.
- Counts sent and dropped packets for emulation statistics.

Parameters:
- X_NODES, 3, mesh width; 1..16
- Y_NODES, 3, mesh height; 1..16
- FIFO_WIDTH, 32, packet width; fixed at 32 for the field layout below
- NODE_ID, 0, this node's linear index (x + y*X_NODES)
- QUEUE_DEPTH, 4, injection queue entries; power of 2, at least 2
- RATE_PERIOD, 8, cycles between generation attempts; at least 1
- DEST_MODE, 0, destination selection: 0 = fixed DEST_ID, 1 = LFSR random
- DEST_ID, 0, destination used when DEST_MODE=0
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  generation enable; the queue keeps draining when low
- networkToNodeHoldRequest  in  1  network cannot accept from this node this cycle
- nodeToNetworkData  out  FIFO_WIDTH  packet presented to the network
- nodeToNetworkWriteRequest  out  1  one-cycle write strobe
- packetsSent  out  16  count of packets written; wraps
- packetsDropped  out  16  count of packets lost to a full queue; saturates at 16'hFFFF
- queueEmpty  out  1  queue holds no packets

Behaviour:
- Only one clock and one reset exist. Reset is synchronous and active-high.
- Reset values: nodeToNetworkData=0, nodeToNetworkWriteRequest=0, packetsSent=0, packetsDropped=0, queueEmpty=1, rate counter=0, sequence=0, LFSR=LFSR_SEED, queue empty.
- Reset asserted mid-operation discards all queued packets. No write strobe appears in the cycle after the reset edge.
- Packet fields:
  - [31] valid=1
  - [30:27] destX, [26:23] destY
  - [22:19] srcX, [18:15] srcY
  - [14:0] sequence
  - srcX = NODE_ID % X_NODES; srcY = NODE_ID / X_NODES.
- Rate counter:
  - Counts 0..RATE_PERIOD-1 and wraps; it runs whenever reset is low, regardless of enable.
  - A generation event occurs on the edge where the counter equals RATE_PERIOD-1 and enable=1.
  - With enable held high from reset release, the first event is at the RATE_PERIOD-th edge.
- Destination selection:
  - DEST_MODE=0: destination index = DEST_ID.
  - DEST_MODE=1: idx = LFSR % (X_NODES*Y_NODES). If idx == NODE_ID, use (idx+1) % N.
  - The LFSR is a 16-bit Fibonacci LFSR, taps 16,14,13,11. It advances only on generation events.
  - destX = idx % X_NODES; destY = idx / X_NODES.
- Generation event:
  - Accepted if the queue is not full, or if a pop occurs on the same edge. Simultaneous push and pop on a full queue is legal.
  - An accepted event pushes the packet and increments the 15-bit sequence, which wraps 0x7FFF to 0.
  - A rejected event increments packetsDropped (saturating). The sequence still increments, so gaps are visible at the sink.
- Drain:
  - On each edge, if the queue is non-empty and networkToNodeHoldRequest=0 (sampled at that edge), register the head into nodeToNetworkData, set nodeToNetworkWriteRequest=1, pop, and increment packetsSent.
  - Otherwise nodeToNetworkWriteRequest=0 and nodeToNetworkData holds its last value.
  - At most one write per cycle.
- Latency: a push at edge N makes the earliest strobe visible after edge N+1. Minimum latency is 1 cycle; the queue does not bypass.
- Hold held high indefinitely: the queue fills, then every further event is dropped. Nothing is lost once accepted.
- Bubble-free: back-to-back writes occur on consecutive cycles while the queue is non-empty and hold is low.

Decomposition:
- Package node_packet_pkg holds:
  - field position/width constants: VALID_BIT=31, DEST_X_LSB=27, DEST_Y_LSB=23, SRC_X_LSB=19, SRC_Y_LSB=15, SEQ_BITS=15, COORD_BITS=4
  - a packed struct type packet_t
  - a function for the LFSR next-state
- Sub-module node_source_fifo is a synchronous FIFO with QUEUE_DEPTH entries. It provides push, pop, full, empty, and head data, and allows simultaneous push/pop when full.
- The top level contains the rate counter, LFSR, packet builder, drain register and counters.

Test Plan:
- 3x3, NODE_ID=8, DEST_MODE=0, DEST_ID=0, RATE_PERIOD=8, enable=1, hold=0 -> first strobe with nodeToNetworkData=32'h80110000 one cycle after the 8th post-reset edge. Second strobe has data=32'h80110001, 8 cycles later. packetsSent=2.
- Same setup, hold=1 for 60 cycles -> no strobes. queueEmpty=0 after the first event. After the 4th accepted packet, packetsDropped increments once per event.
- Release hold after the previous scenario -> 4 strobes on 4 consecutive cycles with sequences 0,1,2,3, then the next strobe carries the next accepted sequence (gap visible).
- DEST_MODE=1, NODE_ID=4, 200 cycles -> no packet has destX=1, destY=1. All destX and destY values are less than 3.
- RATE_PERIOD=1, QUEUE_DEPTH=4, hold=0 -> steady strobe every cycle, packetsDropped stays 0, and the queue never exceeds 1 entry.
- Assert reset for 1 cycle while 3 packets are queued -> the next cycle has writeRequest=0, queueEmpty=1 and all counters 0. The next packet's sequence is 0.
